// File: rtl/lif_neuron_bank.sv
// lif_neuron_bank: a bank of N leaky integrate-and-fire neurons.
//
// Each accepted input beat is one network timestep. On that step every neuron
// leaks, integrates its own signed contribution, compares against the
// threshold, fires, and then holds through its refractory period. The spike
// vector, the membrane potentials and the timestep index go out through a
// single output register that has a valid/ready handshake.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        synchronous reset, active high
//   in_valid   in_data holds one timestep of contributions
//   in_data    N lanes of WW-bit signed contributions (lane i = [i*WW +: WW])
//   in_ready   the bank can take a beat this cycle
//   out_valid  spike_out / v_out / ts_count hold a result
//   out_ready  downstream consumes the result this cycle
//   spike_out  bit i = neuron i fired on this timestep
//   v_out      N lanes of VW-bit signed potential after this timestep
//   ts_count   index of the timestep held in the output register

// One neuron. Its potential and spike registers act as that neuron's slice of
// the output register: they change only on accept, so they stay stable while
// the output is stalled.
module lif_lane #(
  parameter int WW         = 3,
  parameter int VW         = 8,
  parameter int THRESH     = 20,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          acc_i,
  input  logic [WW-1:0] c_i,
  output logic [VW-1:0] v_o,
  output logic          spike_o
);
  // At least one bit, so that REFRAC=0 still yields a legal counter.
  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic [RW-1:0]        RLOAD = RW'(REFRAC);
  localparam logic signed [VW+1:0] SMAX  = {3'b000, {(VW-1){1'b1}}};
  localparam logic signed [VW+1:0] SMIN  = {3'b111, {(VW-1){1'b0}}};
  localparam logic signed [VW-1:0] TH    = VW'(THRESH);

  logic signed [VW-1:0] v_q, v_d, v_sh, v_sat;
  logic signed [VW+1:0] s;
  logic [RW-1:0]        r_q, r_d;
  logic                 spk_q, spk_d, fire;

  // Floor shift on the signed potential. The sum is formed two bits wider
  // than V, so neither the leak nor the contribution can wrap before
  // saturation.
  assign v_sh  = v_q >>> LEAK_SHIFT;
  assign s     = {{2{v_q[VW-1]}}, v_q} - {{2{v_sh[VW-1]}}, v_sh}
               + {{(VW+2-WW){c_i[WW-1]}}, c_i};
  assign v_sat = (s > SMAX) ? SMAX[VW-1:0] :
                 (s < SMIN) ? SMIN[VW-1:0] : s[VW-1:0];
  assign fire  = (v_sat >= TH);

  always_comb begin
    v_d   = v_q;
    r_d   = r_q;
    spk_d = spk_q;
    if (acc_i) begin
      if (r_q != '0) begin
        // Refractory: the contribution is dropped and the potential is held at 0.
        r_d   = r_q - RW'(1);
        v_d   = '0;
        spk_d = 1'b0;
      end else if (fire) begin
        r_d   = RLOAD;
        v_d   = '0;
        spk_d = 1'b1;
      end else begin
        v_d   = v_sat;
        spk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      r_q   <= '0;
      spk_q <= 1'b0;
    end else begin
      v_q   <= v_d;
      r_q   <= r_d;
      spk_q <= spk_d;
    end
  end

  assign v_o     = v_q;
  assign spike_o = spk_q;
endmodule

module lif_neuron_bank #(
  parameter int N          = 16,
  parameter int WW         = 3,
  parameter int VW         = 8,
  parameter int THRESH     = 20,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N*WW-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    spike_out,
  output logic [N*VW-1:0] v_out,
  output logic [15:0]     ts_count
);
  logic [N-1:0][WW-1:0] c_lanes;
  logic [N-1:0][VW-1:0] v_lanes;
  logic                 acc;
  logic                 out_valid_q, out_valid_d;
  logic [15:0]          cnt_q, cnt_d, ts_q, ts_d;

  assign c_lanes = in_data;
  assign v_out   = v_lanes;

  // A new beat may enter when the output slot is empty or is being drained in
  // this same cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;

  for (genvar i = 0; i < N; i++) begin : g_lane
    lif_lane #(
      .WW(WW), .VW(VW), .THRESH(THRESH),
      .LEAK_SHIFT(LEAK_SHIFT), .REFRAC(REFRAC)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .acc_i  (acc),
      .c_i    (c_lanes[i]),
      .v_o    (v_lanes[i]),
      .spike_o(spike_out[i])
    );
  end

  always_comb begin
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    ts_d        = ts_q;
    if (acc) begin
      out_valid_d = 1'b1;
      ts_d        = cnt_q;
      cnt_d       = cnt_q + 16'd1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      ts_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      ts_q        <= ts_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ts_count  = ts_q;
endmodule

// File: tb/tb_lif_neuron_bank.sv
module tb_lif_neuron_bank;
  localparam int N = 16, WW = 3, VW = 8;

  logic            clk = 1'b0;
  logic            rst, in_valid, out_ready;
  logic [N*WW-1:0] in_data;
  logic            in_ready, out_valid;
  logic [N-1:0]    spike_out;
  logic [N*VW-1:0] v_out;
  logic [15:0]     ts_count;

  lif_neuron_bank dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .spike_out(spike_out), .v_out(v_out), .ts_count(ts_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    spk;
    logic [N*VW-1:0] v;
    logic [15:0]     ts;
  } res_t;

  typedef struct {
    bit rp;      // reset before this vector
    int lane;
    int c;
    int ev;      // expected potential on that lane
    bit es;      // expected spike on that lane
    int ets;     // expected timestep index
  } vec_t;

  res_t sb[$];
  int   mv[N];
  int   mr[N];
  int   mcnt;
  bit   m_valid;
  int   n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [N*VW-1:0] act, input logic [N*VW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin mv[i] = 0; mr[i] = 0; end
    mcnt = 0;
    m_valid = 0;
    sb.delete();
  endfunction

  // Reference neuron model written in plain integer arithmetic.
  function automatic res_t model_step(input logic [N*WW-1:0] d);
    res_t e;
    e.spk = '0;
    e.v   = '0;
    for (int i = 0; i < N; i++) begin
      int c, lk, s;
      c = $signed(d[i*WW +: WW]);
      if (mr[i] > 0) begin
        mr[i]--;
        mv[i] = 0;
      end else begin
        lk = (mv[i] >= 0) ? mv[i] / 8 : -((-mv[i] + 7) / 8);
        s  = mv[i] - lk + c;
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
        if (s >= 20) begin
          e.spk[i] = 1'b1;
          mv[i] = 0;
          mr[i] = 4;
        end else begin
          mv[i] = s;
        end
      end
      e.v[i*VW +: VW] = mv[i][VW-1:0];
    end
    e.ts = mcnt[15:0];
    mcnt = (mcnt + 1) % 65536;
    return e;
  endfunction

  // Drive one cycle. Check the handshake and the held result at negedge, let
  // the model follow the accept/consume decision, then return 1 ns after the
  // edge.
  task automatic cycle(input bit r, input bit v, input logic [N*WW-1:0] d, input bit rdy);
    bit acc;
    rst = r; in_valid = v; in_data = d; out_ready = rdy;
    @(negedge clk);
    chk("in_ready", {127'b0, in_ready}, {127'b0, !m_valid || rdy});
    chk("out_valid", {127'b0, out_valid}, {127'b0, m_valid});
    if (m_valid) begin
      if (sb.size() == 0) chk("sb_empty", 128'd1, 128'd0);
      else begin
        chk("sb_spike", {112'b0, spike_out}, {112'b0, sb[0].spk});
        chk("sb_v", v_out, sb[0].v);
        chk("sb_ts", {112'b0, ts_count}, {112'b0, sb[0].ts});
      end
    end
    if (r) model_reset();
    else begin
      acc = v && (!m_valid || rdy);
      if (m_valid && rdy && sb.size() > 0) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(model_step(d));
        m_valid = 1;
      end else if (rdy) m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*WW-1:0] lane_data(input int lane, input int c);
    logic [N*WW-1:0] d;
    logic [31:0]     cv;
    d  = '0;
    cv = c;
    d[lane*WW +: WW] = cv[WW-1:0];
    return d;
  endfunction

  vec_t tbl[30];
  int   vB[15] = '{-4, -7, -10, -12, -14, -16, -18, -19, -20, -21, -22, -23, -24, -25, -25};
  int   vA[15] = '{3, 6, 9, 11, 13, 15, 17, 18, 19, 0, 0, 0, 0, 0, 3};

  initial begin
    logic [N*WW-1:0] d;
    logic [15:0]     ts_hold;
    logic [31:0]     evw;

    for (int k = 0; k < 15; k++) begin
      tbl[k]      = '{rp: (k == 0), lane: 0, c: 3, ev: vA[k], es: (k == 9), ets: k};
      tbl[15 + k] = '{rp: (k == 0), lane: 5, c: -4, ev: vB[k], es: 1'b0, ets: k};
    end

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    chk("rst_spike", {112'b0, spike_out}, 128'd0);
    chk("rst_v", v_out, '0);
    chk("rst_ts", {112'b0, ts_count}, 128'd0);

    // Table: +3 on lane 0 through fire and refractory; then -4 on lane 5.
    for (int k = 0; k < 30; k++) begin
      if (tbl[k].rp) begin
        cycle(1, 0, '0, 1);
        cycle(1, 0, '0, 1);
      end
      cycle(0, 1, lane_data(tbl[k].lane, tbl[k].c), 1);
      evw = tbl[k].ev;
      chk("tbl_v", {120'b0, v_out[tbl[k].lane*VW +: VW]}, {120'b0, evw[VW-1:0]});
      chk("tbl_spike", {112'b0, spike_out}, {112'b0, (tbl[k].es ? (16'd1 << tbl[k].lane) : 16'd0)});
      chk("tbl_ts", {112'b0, ts_count}, {112'b0, tbl[k].ets[15:0]});
    end

    // Backpressure: stream, stall 3 cycles, release, then bubbles.
    cycle(1, 0, '0, 1);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) d[i*WW +: WW] = 3'($urandom_range(0, 7));
      cycle(0, 1, d, 1);
    end
    ts_hold = ts_count;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) d[i*WW +: WW] = 3'($urandom_range(0, 7));
      cycle(0, 1, d, 0);
      chk("stall_ts_frozen", {112'b0, ts_count}, {112'b0, ts_hold});
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) d[i*WW +: WW] = 3'($urandom_range(0, 7));
      cycle(0, 1, d, 1);
      if (k == 0) chk("release_ts", {112'b0, ts_count}, {112'b0, ts_hold + 16'd1});
    end
    cycle(0, 0, '0, 1);
    cycle(0, 0, '0, 0);
    cycle(0, 1, lane_data(2, 1), 0);
    cycle(0, 0, '0, 1);

    // All lanes fire together on the tenth beat of +3.
    cycle(1, 0, '0, 1);
    for (int k = 0; k < 10; k++) cycle(0, 1, {N{3'b011}}, 1);
    chk("all_fire_spike", {112'b0, spike_out}, {112'b0, 16'hFFFF});
    chk("all_fire_v", v_out, '0);

    // Reset while holding a result, colliding with an accept.
    cycle(1, 0, '0, 1);
    for (int k = 0; k < 6; k++) cycle(0, 1, lane_data(0, 3), 1);
    chk("pre_rst_valid", {127'b0, out_valid}, 128'd1);
    cycle(1, 1, lane_data(0, 3), 1);
    chk("mid_rst_valid", {127'b0, out_valid}, 128'd0);
    chk("mid_rst_spike", {112'b0, spike_out}, 128'd0);
    chk("mid_rst_v", v_out, '0);
    chk("mid_rst_ts", {112'b0, ts_count}, 128'd0);
    cycle(0, 1, lane_data(0, 3), 1);
    chk("post_rst_v0", {120'b0, v_out[VW-1:0]}, 128'd3);
    chk("post_rst_ts", {112'b0, ts_count}, 128'd0);
    cycle(0, 0, '0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
